// File: rtl/hls_ram_responder.sv
// Array storage responder for HLS kernel port bundles: combinational reads,
// edge-triggered writes with clear > kernel > debug priority, and a clear engine.
module hls_ram_responder #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] raddr_0,
  output logic [WIDTH-1:0]      rdata_0,
  input  logic [ADDR_WIDTH-1:0] waddr_0,
  input  logic [WIDTH-1:0]      wdata_0,
  input  logic                  wen_0,
  input  logic [ADDR_WIDTH-1:0] debug_addr,
  output logic [WIDTH-1:0]      debug_data,
  input  logic [ADDR_WIDTH-1:0] debug_write_addr,
  input  logic [WIDTH-1:0]      debug_write_data,
  input  logic                  debug_write_en,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic [31:0]           wr_count
);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [WIDTH-1:0]      mem [DEPTH];
  logic                  kernel_ok;
  logic                  debug_ok;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH_EXT;
  endfunction

  assign rdata_0    = in_range(raddr_0)    ? mem[raddr_0]    : '0;
  assign debug_data = in_range(debug_addr) ? mem[debug_addr] : '0;
  assign kernel_ok  = wen_0 && in_range(waddr_0);
  assign debug_ok   = debug_write_en && in_range(debug_write_addr);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clear_start) state_next = CLEAR;
      CLEAR:   if (clr_addr == LAST_ADDR) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    clear_busy = (state == CLEAR);
    clear_done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst)                             clr_addr <= '0;
    else if (state == IDLE && clear_start) clr_addr <= '0;
    else if (state == CLEAR)             clr_addr <= clr_addr + 1'b1;
  end

  // Kernel write is issued after the debug write so it wins a same-address collision;
  // a reset edge during CLEAR aborts without zeroing the current word.
  always_ff @(posedge clk) begin
    if (clear_busy) begin
      if (!rst) mem[clr_addr] <= '0;
    end else begin
      if (debug_ok)  mem[debug_write_addr] <= debug_write_data;
      if (kernel_ok) mem[waddr_0]          <= wdata_0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      wr_count <= '0;
    else if (!clear_busy && kernel_ok && wr_count != 32'hFFFF_FFFF)
      wr_count <= wr_count + 32'd1;
  end

endmodule

// File: tb/tb_hls_ram_responder.sv
// Scoreboard bench for hls_ram_responder: a default 256-word instance and a
// 200-word instance share kernel traffic and are checked against an array model.
module tb_hls_ram_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  raddr, waddr, dbg_addr, dbg_waddr;
   logic [31:0] wdata, dbg_wdata;
   logic        wen, dbg_wen, clear_start;

   logic [31:0] rdata, ddata, count;
   logic        busy, done;
   logic [31:0] rdata2, ddata2, count2;
   logic        busy2, done2;

   // Free-running clock with a 10 time-unit period
   always #5 clk = ~clk;

   hls_ram_responder dut (
      .clk(clk), .rst(rst),
      .raddr_0(raddr), .rdata_0(rdata),
      .waddr_0(waddr), .wdata_0(wdata), .wen_0(wen),
      .debug_addr(dbg_addr), .debug_data(ddata),
      .debug_write_addr(dbg_waddr), .debug_write_data(dbg_wdata), .debug_write_en(dbg_wen),
      .clear_start(clear_start), .clear_busy(busy), .clear_done(done),
      .wr_count(count)
   );

   hls_ram_responder #(.WIDTH(32), .DEPTH(200), .ADDR_WIDTH(8)) dut2 (
      .clk(clk), .rst(rst),
      .raddr_0(raddr), .rdata_0(rdata2),
      .waddr_0(waddr), .wdata_0(wdata), .wen_0(wen),
      .debug_addr(dbg_addr), .debug_data(ddata2),
      .debug_write_addr(8'd0), .debug_write_data(32'd0), .debug_write_en(1'b0),
      .clear_start(1'b0), .clear_busy(busy2), .clear_done(done2),
      .wr_count(count2)
   );

   // Reference model: word arrays with known-value flags, clear progress as words remaining
   logic [31:0] m1 [256];
   bit          v1 [256];
   logic [31:0] m2 [256];
   bit          v2 [256];
   int unsigned cnt1, cnt2;
   int          clr_left;
   bit          done_m;
   int          busyRun = 0;

   typedef struct {int kind; logic [31:0] exp;} chk_t;
   chk_t q[$];
   int   errors = 0;
   int   checks = 0;

   function automatic string kname(input int k);
      case (k)
         0: return "rdata_0";
         1: return "debug_data";
         2: return "wr_count";
         3: return "clear_busy";
         4: return "clear_done";
         5: return "rdata_0_d200";
         6: return "debug_data_d200";
         default: return "wr_count_d200";
      endcase
   endfunction

   // Monitor: at each falling edge drain the queued expectations and compare against the DUT outputs
   always @(negedge clk) begin
      while (q.size() > 0) begin
         chk_t c;
         logic [31:0] act;
         c = q.pop_front();
         case (c.kind)
            0: act = rdata;
            1: act = ddata;
            2: act = count;
            3: act = {31'd0, busy};
            4: act = {31'd0, done};
            5: act = rdata2;
            6: act = ddata2;
            default: act = count2;
         endcase
         checks++;
         if (act !== c.exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", kname(c.kind), $time, act, c.exp);
         end
      end
   end

   // Watchdog: clear_busy must never stay high longer than DEPTH consecutive edges
   always @(posedge clk) begin
      if (busy) busyRun++;
      else      busyRun = 0;
      checks++;
      if (busyRun > 256) begin
         errors++;
         $display("[TB] FAIL clear_busy held for %0d cycles at %0t (limit 256)", busyRun, $time);
         busyRun = 0;
      end
   end

   // Global timeout: a run that never reaches the end is a failure
   initial begin
      #2000000;
      errors++;
      $display("[TB] FAIL timeout expired at %0t waiting for test completion", $time);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   task automatic checkOutput(input int kind, input logic [31:0] exp);
      chk_t c;
      c.kind = kind;
      c.exp  = exp;
      q.push_back(c);
   endtask

   task automatic checkNow(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic checkResetState();
      checkNow("reset clear_busy", {31'd0, busy}, 32'd0);
      checkNow("reset clear_done", {31'd0, done}, 32'd0);
      checkNow("reset wr_count", count, 32'd0);
      checkNow("reset wr_count_d200", count2, 32'd0);
   endtask

   task automatic modelEdge();
      if (rst) begin
         cnt1 = 0; cnt2 = 0; clr_left = 0; done_m = 0;
      end else begin
         if (clr_left > 0) begin
            m1[256 - clr_left] = 32'd0;
            v1[256 - clr_left] = 1;
            clr_left--;
            if (clr_left == 0) done_m = 1;
         end else begin
            if (dbg_wen) begin m1[dbg_waddr] = dbg_wdata; v1[dbg_waddr] = 1; end
            if (wen) begin
               m1[waddr] = wdata; v1[waddr] = 1;
               if (cnt1 != 32'hFFFF_FFFF) cnt1++;
            end
            if (done_m) done_m = 0;
            else if (clear_start) clr_left = 256;
         end
         if (wen && waddr < 8'd200) begin
            m2[waddr] = wdata; v2[waddr] = 1;
            if (cnt2 != 32'hFFFF_FFFF) cnt2++;
         end
      end
   endtask

   // One clock: queue expectations from the model, let the monitor check, then advance the model
   task automatic applyStimulus();
      if (v1[raddr])    checkOutput(0, m1[raddr]);
      if (v1[dbg_addr]) checkOutput(1, m1[dbg_addr]);
      checkOutput(2, cnt1);
      checkOutput(3, {31'd0, clr_left > 0});
      checkOutput(4, {31'd0, done_m});
      if (raddr >= 8'd200)    checkOutput(5, 32'd0);
      else if (v2[raddr])     checkOutput(5, m2[raddr]);
      if (dbg_addr >= 8'd200) checkOutput(6, 32'd0);
      else if (v2[dbg_addr])  checkOutput(6, m2[dbg_addr]);
      checkOutput(7, cnt2);
      @(negedge clk);
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   task automatic quiet();
      rst = 0; wen = 0; dbg_wen = 0; clear_start = 0;
   endtask

   task automatic fillAll();
      for (int i = 0; i < 256; i++) begin
         quiet();
         waddr = 8'(i); wdata = 32'hFFFF_FFFF; wen = 1;
         raddr = 8'($urandom_range(0, 255)); dbg_addr = 8'($urandom_range(0, 255));
         applyStimulus();
      end
      quiet();
   endtask

   task automatic sweep();
      for (int i = 0; i < 256; i++) begin
         raddr = 8'(i); dbg_addr = 8'(255 - i);
         applyStimulus();
      end
   endtask

   // Main sequence: directed test-plan items followed by constrained-random traffic
   initial begin
      for (int i = 0; i < 256; i++) begin v1[i] = 0; v2[i] = 0; m1[i] = '0; m2[i] = '0; end
      quiet();
      raddr = 0; waddr = 0; wdata = 0; dbg_addr = 0; dbg_waddr = 0; dbg_wdata = 0;
      rst = 1;
      repeat (2) @(posedge clk);
      modelEdge();
      #1;
      checkResetState();
      quiet();
      applyStimulus();

      dbg_waddr = 8'd5; dbg_wdata = 32'h11; dbg_wen = 1; applyStimulus();
      dbg_waddr = 8'd6; dbg_wdata = 32'h22; applyStimulus();
      quiet();
      raddr = 8'd5; dbg_addr = 8'd6;
      checkOutput(0, 32'h11);
      checkOutput(1, 32'h22);
      applyStimulus();

      for (int i = 0; i < 3; i++) begin
         raddr = 8'd5; waddr = 8'd5; wdata = m1[5] + 32'd1; wen = 1;
         applyStimulus();
      end
      quiet();
      checkOutput(0, 32'h14);
      checkOutput(2, 32'd3);
      applyStimulus();

      waddr = 8'd9; wdata = 32'hAA; wen = 1;
      dbg_waddr = 8'd9; dbg_wdata = 32'hBB; dbg_wen = 1;
      applyStimulus();
      quiet();
      raddr = 8'd9;
      checkOutput(0, 32'hAA);
      checkOutput(2, 32'd4);
      applyStimulus();

      fillAll();
      clear_start = 1;
      applyStimulus();
      quiet();
      for (int k = 0; k < 260; k++) begin
         raddr = 8'($urandom_range(0, 255)); dbg_addr = 8'($urandom_range(0, 255));
         wen = (k == 50); waddr = 8'd3; wdata = 32'h1234;
         dbg_wen = (k == 60); dbg_waddr = 8'd4; dbg_wdata = 32'h5678;
         clear_start = (k == 100);
         applyStimulus();
      end
      quiet();
      sweep();

      fillAll();
      clear_start = 1;
      applyStimulus();
      quiet();
      for (int k = 0; k < 100; k++) begin
         raddr = 8'($urandom_range(0, 255)); dbg_addr = 8'($urandom_range(0, 255));
         applyStimulus();
      end
      rst = 1;
      applyStimulus();
      checkResetState();
      quiet();
      raddr = 8'd99;  checkOutput(0, 32'd0);
      dbg_addr = 8'd100; checkOutput(1, 32'hFFFF_FFFF);
      checkOutput(2, 32'd0);
      applyStimulus();
      sweep();

      waddr = 8'd250; wdata = 32'hCAFE; wen = 1;
      applyStimulus();
      quiet();
      raddr = 8'd250;
      checkOutput(5, 32'd0);
      checkOutput(7, 32'd0);
      applyStimulus();

      for (int k = 0; k < 500; k++) begin
         raddr = 8'($urandom_range(0, 255));
         waddr = ($urandom_range(0, 3) == 0) ? raddr : 8'($urandom_range(0, 255));
         wdata = $urandom;
         wen = 1'($urandom_range(0, 1));
         dbg_addr = 8'($urandom_range(0, 255));
         dbg_waddr = ($urandom_range(0, 3) == 0) ? waddr : 8'($urandom_range(0, 255));
         dbg_wdata = $urandom;
         dbg_wen = 1'($urandom_range(0, 1));
         clear_start = ($urandom_range(0, 99) == 0);
         applyStimulus();
      end
      quiet();
      applyStimulus();
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hls_ram_responder.md
Name: hls_ram_responder

Overview:
- Memory-side responder for the HLS array-argument port bundle: raddr_0/rdata_0, waddr_0/wdata_0/wen_0, plus debug read/write ports.
- Emitted kernels such as histogram drive this bundle as initiator. This block is the array storage that answers them in both testbench and synthesized wrappers.
- Provides zero-latency combinational read and write-on-clock-edge. This is the timing the kernels rely on for same-stage read-modify-write.
- Also provides a hardware clear engine and an accepted-write counter for verification.

Parameters:
- WIDTH, 32, data word width.
- DEPTH, 256, number of words; legal range 1..2^ADDR_WIDTH.
- ADDR_WIDTH, 8, width of all address ports.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- raddr_0  input  ADDR_WIDTH  kernel read address
- rdata_0  output  WIDTH  kernel read data
- waddr_0  input  ADDR_WIDTH  kernel write address
- wdata_0  input  WIDTH  kernel write data
- wen_0  input  1  kernel write enable
- debug_addr  input  ADDR_WIDTH  bench read address
- debug_data  output  WIDTH  bench read data
- debug_write_addr  input  ADDR_WIDTH  bench write address
- debug_write_data  input  WIDTH  bench write data
- debug_write_en  input  1  bench write enable
- clear_start  input  1  one-cycle request to zero all words
- clear_busy  output  1  clear engine active
- clear_done  output  1  one-cycle pulse when clear completes
- wr_count  output  32  accepted kernel writes since reset

Behaviour:
- Reset (rst=1 at posedge):
  - FSM goes to IDLE; clear_busy=0, clear_done=0, wr_count=0, clear address counter=0.
  - Memory contents are NOT modified by reset.
- Reads:
  - rdata_0 = mem[raddr_0] and debug_data = mem[debug_addr], both combinational with zero latency.
  - A read of an address being written in the same cycle returns the OLD value. The new value is visible from the cycle after the edge.
  - Address >= DEPTH reads return 0.
- Writes:
  - Take effect at posedge clk.
  - Address >= DEPTH writes are ignored and do not count.
- Write priority per edge: clear engine > kernel write (wen_0) > debug write.
  - A lower-priority write loses only when it targets the same address as a higher-priority write in that cycle.
  - Writes to different addresses in the same cycle both complete.
  - While clear_busy=1, kernel and debug writes are fully ignored and wr_count does not increment.
- wr_count:
  - Increments by 1 on each accepted kernel write.
  - Saturates at 32'hFFFFFFFF.
  - Debug writes and clear writes do not count.
- FSM states:
  - IDLE: clear_start=1 -> CLEAR, addr counter=0, clear_busy=1 from the next cycle.
  - CLEAR: each cycle writes 0 to mem[counter] and increments the counter. After writing DEPTH-1 -> DONE. Total of exactly DEPTH clear cycles.
  - DONE: clear_busy=0, clear_done=1 for exactly one cycle, then IDLE.
  - clear_start is ignored in CLEAR and DONE.
  - Reads remain live during CLEAR and reflect partially cleared contents.
- Reset mid-clear: abort immediately to IDLE. Already-zeroed words stay zero, the rest are unchanged, and no clear_done is issued.
- DEPTH=1: CLEAR lasts one cycle.

Test Plan:
- Debug-write mem[5]=0x11 and mem[6]=0x22, then set raddr_0=5 -> rdata_0=0x11 in the same cycle; debug_addr=6 -> debug_data=0x22.
- Read-modify-write: raddr_0=waddr_0=5, wdata_0=rdata_0+1, wen_0=1 for 3 consecutive cycles starting at mem[5]=0x11 -> mem[5]=0x14, wr_count=3.
- Same-cycle collision: wen_0 and debug_write_en both target address 9, with wdata_0=0xAA and debug_write_data=0xBB -> mem[9]=0xAA, wr_count+1.
- Clear with DEPTH=256 after filling all words with 0xFFFFFFFF:
  - Pulse clear_start -> clear_busy high for 256 cycles, then clear_done high for 1 cycle; every word reads 0.
  - A wen_0 issued mid-clear is ignored and wr_count is unchanged.
- Assert rst after 100 CLEAR cycles:
  - clear_busy=0, no clear_done, wr_count=0.
  - Words 0..99 read 0 and words 100..255 read 0xFFFFFFFF.
- Configure DEPTH=200 with ADDR_WIDTH=8: write address 250 -> ignored, wr_count unchanged; raddr_0=250 -> rdata_0=0.
